// File: rtl/riscv_csr_pkg.sv
// Shared definitions for the machine-mode trap logic: FSM states,
// mcause codes, CSR addresses and the vectored-offset helper.
package riscv_csr_pkg;

    typedef enum logic [1:0] {
        ST_OPERATING   = 2'b00,
        ST_TRAP_TAKEN  = 2'b01,
        ST_TRAP_RETURN = 2'b10
    } trap_state_e;

    // Exception codes (mcause[31] = 0)
    localparam logic [3:0] CAUSE_INSTR_MISALIGN = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL        = 4'd2;
    localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;

    // Interrupt codes (mcause[31] = 1)
    localparam logic [3:0] CAUSE_M_SW_IRQ       = 4'd3;
    localparam logic [3:0] CAUSE_M_TIMER_IRQ    = 4'd7;
    localparam logic [3:0] CAUSE_M_EXT_IRQ      = 4'd11;

    // CSR addresses served by the CSR file this block talks to
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;

    // Vectored mode places each interrupt handler at base + 4*cause.
    function automatic logic [31:0] vector_offset(input logic [3:0] cause);
        return {26'd0, cause, 2'b00};
    endfunction

endpackage

// File: rtl/trap_vector_gen.sv
// Computes the trap handler address from mtvec. Only interrupts taken
// with mode 1 are vectored; exceptions and modes 0/2/3 go to the base.
module trap_vector_gen
    import riscv_csr_pkg::*;
(
    input  logic [29:0] base_in,
    input  logic [1:0]  mode_in,
    input  logic [3:0]  cause_in,
    input  logic        is_int_in,
    output logic [31:0] target_out
);

    // Select direct or vectored target; sum wraps at 32 bits.
    always_comb begin
        target_out = {base_in, 2'b00};
        if (is_int_in && (mode_in == 2'b01)) begin
            target_out = {base_in, 2'b00} + vector_offset(cause_in);
        end else begin
            target_out = {base_in, 2'b00};
        end
    end

endmodule

// File: rtl/machine_trap_ctrl.sv
// Machine-mode trap sequencer: detects exceptions/interrupts, emits a
// one-cycle trap-entry or MRET-return strobe set and the redirect target.
module machine_trap_ctrl
    import riscv_csr_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] epc_in,
    input  logic [29:0] mtvec_base_in,
    input  logic [1:0]  mtvec_mode_in,
    input  logic        mie_in,
    input  logic        meie_in,
    input  logic        mtie_in,
    input  logic        msie_in,
    input  logic        e_irq_in,
    input  logic        t_irq_in,
    input  logic        s_irq_in,
    input  logic        illegal_instr_in,
    input  logic        instr_misalign_in,
    input  logic        load_misalign_in,
    input  logic        store_misalign_in,
    input  logic        mret_in,
    output logic        set_epc_out,
    output logic [31:0] epc_capture_out,
    output logic        set_cause_out,
    output logic [3:0]  cause_out,
    output logic        int_or_exc_out,
    output logic        mie_clear_out,
    output logic        mie_set_out,
    output logic        redirect_out,
    output logic [31:0] trap_pc_out,
    output logic        flush_out
);

    trap_state_e r_state;
    logic        r_set_epc;
    logic [31:0] r_epc_capture;
    logic        r_set_cause;
    logic [3:0]  r_cause;
    logic        r_int_or_exc;
    logic        r_mie_clear;
    logic        r_mie_set;
    logic        r_redirect;
    logic [31:0] r_trap_pc;
    logic        r_flush;

    logic        w_e_irq;
    logic        w_s_irq;
    logic        w_t_irq;
    logic        w_trap;
    logic [3:0]  w_cause;
    logic        w_is_int;
    logic [31:0] w_vec_target;
    logic [1:0]  w_unused_epc_lsb;

    // mepc is always word-aligned on return; its low bits are dropped.
    assign w_unused_epc_lsb = epc_in[1:0];

    assign w_e_irq = e_irq_in & meie_in & mie_in;
    assign w_s_irq = s_irq_in & msie_in & mie_in;
    assign w_t_irq = t_irq_in & mtie_in & mie_in;

    // Priority select of the highest trap candidate this cycle.
    always_comb begin
        w_trap   = 1'b0;
        w_cause  = 4'd0;
        w_is_int = 1'b0;
        if (instr_misalign_in) begin
            w_trap  = 1'b1;
            w_cause = CAUSE_INSTR_MISALIGN;
        end else if (illegal_instr_in) begin
            w_trap  = 1'b1;
            w_cause = CAUSE_ILLEGAL;
        end else if (load_misalign_in) begin
            w_trap  = 1'b1;
            w_cause = CAUSE_LOAD_MISALIGN;
        end else if (store_misalign_in) begin
            w_trap  = 1'b1;
            w_cause = CAUSE_STORE_MISALIGN;
        end else if (w_e_irq) begin
            w_trap   = 1'b1;
            w_cause  = CAUSE_M_EXT_IRQ;
            w_is_int = 1'b1;
        end else if (w_s_irq) begin
            w_trap   = 1'b1;
            w_cause  = CAUSE_M_SW_IRQ;
            w_is_int = 1'b1;
        end else if (w_t_irq) begin
            w_trap   = 1'b1;
            w_cause  = CAUSE_M_TIMER_IRQ;
            w_is_int = 1'b1;
        end else begin
            w_trap   = 1'b0;
            w_cause  = 4'd0;
            w_is_int = 1'b0;
        end
    end

    trap_vector_gen u_vec (
        .base_in    (mtvec_base_in),
        .mode_in    (mtvec_mode_in),
        .cause_in   (w_cause),
        .is_int_in  (w_is_int),
        .target_out (w_vec_target)
    );

    // Trap FSM with registered strobes and held trap/return payload.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state       <= ST_OPERATING;
            r_set_epc     <= 1'b0;
            r_epc_capture <= 32'd0;
            r_set_cause   <= 1'b0;
            r_cause       <= 4'd0;
            r_int_or_exc  <= 1'b0;
            r_mie_clear   <= 1'b0;
            r_mie_set     <= 1'b0;
            r_redirect    <= 1'b0;
            r_trap_pc     <= 32'd0;
            r_flush       <= 1'b0;
        end else begin
            case (r_state)
                ST_OPERATING: begin
                    if (w_trap) begin
                        // Trap beats a simultaneous MRET, which gets flushed.
                        r_state       <= ST_TRAP_TAKEN;
                        r_cause       <= w_cause;
                        r_int_or_exc  <= w_is_int;
                        r_epc_capture <= pc_in;
                        r_trap_pc     <= w_vec_target;
                        r_set_epc     <= 1'b1;
                        r_set_cause   <= 1'b1;
                        r_mie_clear   <= 1'b1;
                        r_mie_set     <= 1'b0;
                        r_redirect    <= 1'b1;
                        r_flush       <= 1'b1;
                    end else if (mret_in) begin
                        r_state     <= ST_TRAP_RETURN;
                        r_trap_pc   <= {epc_in[31:2], 2'b00};
                        r_set_epc   <= 1'b0;
                        r_set_cause <= 1'b0;
                        r_mie_clear <= 1'b0;
                        r_mie_set   <= 1'b1;
                        r_redirect  <= 1'b1;
                        r_flush     <= 1'b1;
                    end else begin
                        r_state     <= ST_OPERATING;
                        r_set_epc   <= 1'b0;
                        r_set_cause <= 1'b0;
                        r_mie_clear <= 1'b0;
                        r_mie_set   <= 1'b0;
                        r_redirect  <= 1'b0;
                        r_flush     <= 1'b0;
                    end
                end
                ST_TRAP_TAKEN, ST_TRAP_RETURN: begin
                    // One-cycle states: inputs ignored, strobes drop.
                    r_state     <= ST_OPERATING;
                    r_set_epc   <= 1'b0;
                    r_set_cause <= 1'b0;
                    r_mie_clear <= 1'b0;
                    r_mie_set   <= 1'b0;
                    r_redirect  <= 1'b0;
                    r_flush     <= 1'b0;
                end
                default: begin
                    r_state     <= ST_OPERATING;
                    r_set_epc   <= 1'b0;
                    r_set_cause <= 1'b0;
                    r_mie_clear <= 1'b0;
                    r_mie_set   <= 1'b0;
                    r_redirect  <= 1'b0;
                    r_flush     <= 1'b0;
                end
            endcase
        end
    end

    assign set_epc_out     = r_set_epc;
    assign epc_capture_out = r_epc_capture;
    assign set_cause_out   = r_set_cause;
    assign cause_out       = r_cause;
    assign int_or_exc_out  = r_int_or_exc;
    assign mie_clear_out   = r_mie_clear;
    assign mie_set_out     = r_mie_set;
    assign redirect_out    = r_redirect;
    assign trap_pc_out     = r_trap_pc;
    assign flush_out       = r_flush;

endmodule
